// File: rtl/tank_shell.sv
// Single-shell projectile controller for the enemy tank: launches from the tank
// centre, steps once per frame tick, retires on a screen edge or a hit, then cools down.
module tank_shell #(
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MAX           = 10'd479,
  parameter logic [9:0] TANK_SIZE       = 10'd32,
  parameter logic [9:0] SHELL_SIZE      = 10'd4,
  parameter logic [9:0] SPEED           = 10'd4,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] tank_X,
  input  logic [9:0] tank_Y,
  input  logic [2:0] tank_dir,
  input  logic       hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] shell_X,
  output logic [9:0] shell_Y,
  output logic [2:0] shell_dir,
  output logic       shell_active,
  output logic       fired,
  output logic       is_shell
);

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} state_t;

  localparam logic [9:0]  LAUNCH_OFS = (TANK_SIZE - SHELL_SIZE) >> 1;
  localparam logic [7:0]  CD_LAST    = (COOLDOWN_FRAMES == 8'd0) ? 8'd0 : COOLDOWN_FRAMES - 8'd1;
  localparam logic [10:0] SPEED_W    = {1'b0, SPEED};
  localparam logic [10:0] SIZE_W     = {1'b0, SHELL_SIZE};
  localparam logic [10:0] X_LIM      = {1'b0, X_MAX} + 11'd1;
  localparam logic [10:0] Y_LIM      = {1'b0, Y_MAX} + 11'd1;

  state_t      state_q;
  logic [9:0]  x_q, y_q;
  logic [2:0]  dir_q;
  logic        active_q, fired_q;
  logic [7:0]  cnt_q;

  logic [10:0] x_w, y_w;
  logic        at_edge;
  logic        dir_ok;

  assign x_w    = {1'b0, x_q};
  assign y_w    = {1'b0, y_q};
  assign dir_ok = (tank_dir >= 3'd1) && (tank_dir <= 3'd4);

  // Widened to 11 bits so a step past either border is detected rather than wrapped.
  always_comb begin
    at_edge = 1'b0;
    case (dir_q)
      3'd1:    at_edge = y_w < SPEED_W;
      3'd2:    at_edge = (x_w + SIZE_W + SPEED_W) > X_LIM;
      3'd3:    at_edge = x_w < SPEED_W;
      3'd4:    at_edge = (y_w + SIZE_W + SPEED_W) > Y_LIM;
      default: at_edge = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= '0;
      active_q <= 1'b0;
      fired_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fired_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire && dir_ok) begin
            state_q  <= FLIGHT;
            fired_q  <= 1'b1;
            active_q <= 1'b1;
            dir_q    <= tank_dir;
            x_q      <= tank_X + LAUNCH_OFS;
            y_q      <= tank_Y + LAUNCH_OFS;
          end
        end
        FLIGHT: begin
          if (hit || (frame_tick && at_edge)) begin
            state_q  <= COOLDOWN;
            active_q <= 1'b0;
            cnt_q    <= '0;
          end else if (frame_tick) begin
            case (dir_q)
              3'd1:    y_q <= y_q - SPEED;
              3'd2:    x_q <= x_q + SPEED;
              3'd3:    x_q <= x_q - SPEED;
              default: y_q <= y_q + SPEED;
            endcase
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt_q == CD_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shell_X      = x_q;
  assign shell_Y      = y_q;
  assign shell_dir    = dir_q;
  assign shell_active = active_q;
  assign fired        = fired_q;

  assign is_shell = active_q
                 && ({1'b0, DrawX} >= x_w) && ({1'b0, DrawX} <= x_w + SIZE_W - 11'd1)
                 && ({1'b0, DrawY} >= y_w) && ({1'b0, DrawY} <= y_w + SIZE_W - 11'd1);

endmodule

// File: tb/tb_tank_shell.sv
// Bench for tank_shell: directed stimulus, a behavioural shell model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_tank_shell;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, fire, hit;
  logic [9:0] tank_X, tank_Y, DrawX, DrawY;
  logic [2:0] tank_dir;
  logic [9:0] shell_X, shell_Y;
  logic [2:0] shell_dir;
  logic       shell_active, fired, is_shell;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  tank_shell dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
    .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir), .hit(hit),
    .DrawX(DrawX), .DrawY(DrawY),
    .shell_X(shell_X), .shell_Y(shell_Y), .shell_dir(shell_dir),
    .shell_active(shell_active), .fired(fired), .is_shell(is_shell)
  );

  always #5 Clk = ~Clk;

  // Model: a flying shell, or a count of frame ticks still to wait before re-arm.
  int m_x = 0, m_y = 0, m_dir = 0;
  bit m_active = 1'b0, m_fired = 1'b0;
  int m_wait = 0;

  always @(posedge Clk) begin
    int nx, ny;
    m_fired = 1'b0;
    if (Reset) begin
      m_x = 0; m_y = 0; m_dir = 0; m_active = 1'b0; m_wait = 0;
    end else if (m_active) begin
      if (hit) begin
        m_active = 1'b0; m_wait = 30;
      end else if (frame_tick) begin
        nx = m_x; ny = m_y;
        if (m_dir == 1) ny = m_y - 4;
        if (m_dir == 2) nx = m_x + 4;
        if (m_dir == 3) nx = m_x - 4;
        if (m_dir == 4) ny = m_y + 4;
        // Retire if the shell would no longer fit fully on screen.
        if (nx < 0 || ny < 0 || nx + 3 > 639 || ny + 3 > 479) begin
          m_active = 1'b0; m_wait = 30;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else if (m_wait > 0) begin
      if (frame_tick) m_wait = m_wait - 1;
    end else if (fire && tank_dir >= 1 && tank_dir <= 4) begin
      m_active = 1'b1; m_fired = 1'b1; m_dir = int'(tank_dir);
      m_x = (int'(tank_X) + 14) % 1024;
      m_y = (int'(tank_Y) + 14) % 1024;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      bit m_pix;
      m_pix = m_active && int'(DrawX) >= m_x && int'(DrawX) < m_x + 4
                       && int'(DrawY) >= m_y && int'(DrawY) < m_y + 4;
      cmp("model shell_X", int'(shell_X), m_x);
      cmp("model shell_Y", int'(shell_Y), m_y);
      cmp("model shell_dir", int'(shell_dir), m_dir);
      cmp("model shell_active", int'(shell_active), int'(m_active));
      cmp("model fired", int'(fired), int'(m_fired));
      cmp("model is_shell", int'(is_shell), int'(m_pix));
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #2;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic launch(input int tx, input int ty, input int d);
    tank_X = 10'(tx); tank_Y = 10'(ty); tank_dir = 3'(d);
    fire = 1'b1;
    cycle();
    fire = 1'b0;
  endtask

  task automatic pix(input string name, input int dx, input int dy, input int exp);
    DrawX = 10'(dx); DrawY = 10'(dy);
    #1;
    cmp(name, int'(is_shell), exp);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0;
    tank_X = '0; tank_Y = '0; tank_dir = '0; DrawX = '0; DrawY = '0;
    cycle(); cycle();
    chk_en = 1'b1;
    cmp("reset shell_X", int'(shell_X), 0);
    cmp("reset active", int'(shell_active), 0);
    cmp("reset fired", int'(fired), 0);
    Reset = 1'b0;
    cycle();

    // Upward launch and pixel window.
    launch(100, 380, 1);
    cmp("up fired", int'(fired), 1);
    cmp("up active", int'(shell_active), 1);
    cmp("up launch X", int'(shell_X), 114);
    cmp("up launch Y", int'(shell_Y), 394);
    pix("pix 114,394", 114, 394, 1);
    pix("pix 117,397", 117, 397, 1);
    pix("pix 118,394", 118, 394, 0);
    pix("pix 113,394", 113, 394, 0);
    cycle();
    cmp("fired one cycle", int'(fired), 0);
    for (int unsigned i = 0; i < 3; i++) tick();
    cmp("up after 3 ticks Y", int'(shell_Y), 382);

    // Hit coincident with frame tick, then fire held through cooldown.
    hit = 1'b1; frame_tick = 1'b1;
    cycle();
    hit = 1'b0; frame_tick = 1'b0;
    cmp("hit active", int'(shell_active), 0);
    cmp("hit no move Y", int'(shell_Y), 382);
    pix("pix cooldown", 114, 382, 0);
    fire = 1'b1;
    for (int unsigned i = 0; i < 29; i++) tick();
    cmp("cooldown 29 no fire", int'(fired), 0);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cmp("cooldown 30th tick", int'(fired), 0);
    cycle();
    cmp("rearm fired", int'(fired), 1);
    fire = 1'b0;
    hit = 1'b1; cycle(); hit = 1'b0;   // hit outside flight below is harmless

    // Reset mid-flight (shell just launched is in flight? it was hit -> use fresh one).
    Reset = 1'b1; cycle(); Reset = 1'b0;
    hit = 1'b1; cycle(); hit = 1'b0;
    launch(200, 200, 4);
    tick();
    Reset = 1'b1; cycle(); Reset = 1'b0;
    cmp("rst flight active", int'(shell_active), 0);
    cmp("rst flight X", int'(shell_X), 0);
    cmp("rst flight dir", int'(shell_dir), 0);
    launch(10, 10, 2);
    cmp("post-reset fired", int'(fired), 1);
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // Right edge retire and exact cooldown length.
    launch(600, 100, 2);
    cmp("right launch X", int'(shell_X), 614);
    for (int unsigned i = 0; i < 5; i++) tick();
    cmp("right 5 ticks X", int'(shell_X), 634);
    tick();
    cmp("right retire active", int'(shell_active), 0);
    cmp("right retire X", int'(shell_X), 634);
    for (int unsigned i = 0; i < 29; i++) tick();
    fire = 1'b1;
    cycle(); cycle();
    cmp("right cd still busy", int'(fired), 0);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    cycle();
    cmp("right rearm fired", int'(fired), 1);
    fire = 1'b0;

    // Reset mid-cooldown.
    hit = 1'b1; cycle(); hit = 1'b0;
    tick(); tick();
    Reset = 1'b1; cycle(); Reset = 1'b0;
    cmp("rst cd X", int'(shell_X), 0);
    cmp("rst cd Y", int'(shell_Y), 0);
    launch(50, 50, 1);
    cmp("rst cd fire accepted", int'(fired), 1);
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // Invalid directions are ignored.
    tank_dir = 3'd0; fire = 1'b1; cycle(); cycle();
    cmp("dir0 fired", int'(fired), 0);
    tank_dir = 3'd5; cycle(); cycle();
    cmp("dir5 active", int'(shell_active), 0);
    tank_dir = 3'd7; cycle(); cycle();
    fire = 1'b0;

    // Left edge: 14 -> 10 -> 6 -> 2, then retire without wrapping.
    launch(0, 200, 3);
    cmp("left launch X", int'(shell_X), 14);
    for (int unsigned i = 0; i < 3; i++) tick();
    cmp("left 3 ticks X", int'(shell_X), 2);
    tick();
    cmp("left retire active", int'(shell_active), 0);
    cmp("left retire X", int'(shell_X), 2);
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // Down edge: 454 .. 474, then retire.
    launch(300, 440, 4);
    for (int unsigned i = 0; i < 5; i++) tick();
    cmp("down 5 ticks Y", int'(shell_Y), 474);
    tick();
    cmp("down retire active", int'(shell_active), 0);
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // Up edge from the top row.
    launch(300, 0, 1);
    for (int unsigned i = 0; i < 4; i++) tick();
    cmp("up edge active", int'(shell_active), 0);
    cmp("up edge Y", int'(shell_Y), 2);
    cycle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
